// File: rtl/riscv_alu_arb.sv
`default_nettype none
// =============================================================================
// riscv_alu_arb : round-robin arbiter sharing one combinational ALU between two
// requesters; define RISCV_ALU_ARB_STAT_EN for grant/conflict counters. Rev 1.0
// =============================================================================
module riscv_alu_arb #(
  parameter int XLEN = 32,
  parameter int CTRW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  logic [CTRW-1:0] req0_ctr_i,
  input  logic [XLEN-1:0] req0_a_i,
  input  logic [XLEN-1:0] req0_b_i,
  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  logic [CTRW-1:0] req1_ctr_i,
  input  logic [XLEN-1:0] req1_a_i,
  input  logic [XLEN-1:0] req1_b_i,
  output logic            rsp0_valid_o,
  input  logic            rsp0_ready_i,
  output logic [XLEN-1:0] rsp0_p_o,
  output logic            rsp0_zero_o,
  output logic            rsp0_less_o,
  output logic            rsp1_valid_o,
  input  logic            rsp1_ready_i,
  output logic [XLEN-1:0] rsp1_p_o,
  output logic            rsp1_zero_o,
  output logic            rsp1_less_o,
  output logic [CTRW-1:0] alu_ctr_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  input  logic [XLEN-1:0] alu_p_i,
  input  logic            alu_zero_i,
  input  logic            alu_less_i
`ifdef RISCV_ALU_ARB_STAT_EN
  ,
  output logic [31:0]     stat_grant0_o,
  output logic [31:0]     stat_grant1_o,
  output logic [31:0]     stat_conflict_o
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            prio_q, gid_q;
  logic [CTRW-1:0] ctr_q, ctr_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, p_q;
  logic            zero_q, less_q;
  logic            w_grant0, w_grant1, w_accept, w_rsp_hs;

  // prio only breaks ties; a lone valid requester always wins
  always_comb begin
    w_grant0 = req0_valid_i & (~req1_valid_i | ~prio_q);
    w_grant1 = req1_valid_i & (~req0_valid_i | prio_q);
    w_accept = (state_q == S_IDLE) & (w_grant0 | w_grant1);
    w_rsp_hs = (state_q == S_RESP) & (gid_q ? rsp1_ready_i : rsp0_ready_i);
    ctr_d    = w_grant1 ? req1_ctr_i : req0_ctr_i;
    a_d      = w_grant1 ? req1_a_i   : req0_a_i;
    b_d      = w_grant1 ? req1_b_i   : req0_b_i;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (w_rsp_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    rsp0_valid_o = 1'b0;
    rsp1_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        req0_ready_o = w_grant0;
        req1_ready_o = w_grant1;
      end
      S_RESP: begin
        rsp0_valid_o = ~gid_q;
        rsp1_valid_o = gid_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
      gid_q  <= 1'b0;
      ctr_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      zero_q <= 1'b0;
      less_q <= 1'b0;
    end else begin
      if (w_accept) begin
        gid_q <= w_grant1;
        ctr_q <= ctr_d;
        a_q   <= a_d;
        b_q   <= b_d;
      end
      if (state_q == S_EXEC) begin
        p_q    <= alu_p_i;
        zero_q <= alu_zero_i;
        less_q <= alu_less_i;
      end
      if (w_rsp_hs) prio_q <= ~gid_q;
    end
  end

  // ALU inputs come straight from the operand registers so they hold through EXEC
  assign alu_ctr_o   = ctr_q;
  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign rsp0_p_o    = p_q;
  assign rsp0_zero_o = zero_q;
  assign rsp0_less_o = less_q;
  assign rsp1_p_o    = p_q;
  assign rsp1_zero_o = zero_q;
  assign rsp1_less_o = less_q;

`ifdef RISCV_ALU_ARB_STAT_EN
  logic [31:0] stat_g0_q, stat_g1_q, stat_cf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_g0_q <= '0;
      stat_g1_q <= '0;
      stat_cf_q <= '0;
    end else begin
      if (w_accept & w_grant0) stat_g0_q <= stat_g0_q + 32'd1;
      if (w_accept & w_grant1) stat_g1_q <= stat_g1_q + 32'd1;
      if ((state_q == S_IDLE) & req0_valid_i & req1_valid_i) stat_cf_q <= stat_cf_q + 32'd1;
    end
  end

  assign stat_grant0_o   = stat_g0_q;
  assign stat_grant1_o   = stat_g1_q;
  assign stat_conflict_o = stat_cf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_alu_arb.sv
`default_nettype none
// =============================================================================
// tb_riscv_alu_arb : scoreboard bench for riscv_alu_arb with a behavioural ALU
// and a transaction-level arbitration model. Rev 1.0
// =============================================================================
module tb_riscv_alu_arb;
  localparam int XLEN  = 32;
  localparam int CTRW  = 4;
  localparam int DEPTH = 256;

  typedef struct packed {
    logic [3:0]  ctr;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic req0_ready_o, req1_ready_o;
  logic [CTRW-1:0] req0_ctr_i = '0, req1_ctr_i = '0;
  logic [XLEN-1:0] req0_a_i = '0, req0_b_i = '0, req1_a_i = '0, req1_b_i = '0;
  logic rsp0_valid_o, rsp1_valid_o;
  logic rsp0_ready_i = 1'b1, rsp1_ready_i = 1'b1;
  logic [XLEN-1:0] rsp0_p_o, rsp1_p_o;
  logic rsp0_zero_o, rsp0_less_o, rsp1_zero_o, rsp1_less_o;
  logic [CTRW-1:0] alu_ctr_o;
  logic [XLEN-1:0] alu_a_o, alu_b_o, alu_p_i;
  logic alu_zero_i, alu_less_i;
`ifdef RISCV_ALU_ARB_STAT_EN
  logic [31:0] stat_grant0_o, stat_grant1_o, stat_conflict_o;
`endif

  always #5 clk = ~clk;

  // Reference ALU: {less, zero, p}
  function automatic logic [33:0] alu_ref(input logic [3:0] ctr, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] p;
    logic lt_s, lt_u;
    lt_s = $signed(a) < $signed(b);
    lt_u = a < b;
    case (ctr)
      4'b0000: p = a + b;
      4'b1000: p = a - b;
      4'b0001: p = a << b[4:0];
      4'b0010: p = {31'd0, lt_s};
      4'b0011: p = {31'd0, lt_u};
      4'b0100: p = a ^ b;
      4'b0101: p = a >> b[4:0];
      4'b1101: p = $signed(a) >>> b[4:0];
      4'b0110: p = a | b;
      4'b0111: p = a & b;
      default: p = b;
    endcase
    return {(ctr == 4'b0011) ? lt_u : lt_s, p == 32'd0, p};
  endfunction

  assign {alu_less_i, alu_zero_i, alu_p_i} = alu_ref(alu_ctr_o, alu_a_o, alu_b_o);

  riscv_alu_arb #(.XLEN(XLEN), .CTRW(CTRW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_ctr_i(req0_ctr_i),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_ctr_i(req1_ctr_i),
    .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i), .rsp0_p_o(rsp0_p_o),
    .rsp0_zero_o(rsp0_zero_o), .rsp0_less_o(rsp0_less_o),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i), .rsp1_p_o(rsp1_p_o),
    .rsp1_zero_o(rsp1_zero_o), .rsp1_less_o(rsp1_less_o),
    .alu_ctr_o(alu_ctr_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_p_i(alu_p_i), .alu_zero_i(alu_zero_i), .alu_less_i(alu_less_i)
`ifdef RISCV_ALU_ARB_STAT_EN
    , .stat_grant0_o(stat_grant0_o), .stat_grant1_o(stat_grant1_o),
    .stat_conflict_o(stat_conflict_o)
`endif
  );

  // Stimulus store: main writes st*/wr*, driver reads and advances rd*
  op_t st0 [DEPTH];
  op_t st1 [DEPTH];
  int  wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
  bit  gaps = 1'b0, rr_rand = 1'b0, man_rdy0 = 1'b1, man_rdy1 = 1'b1;
  int  stat_req = 0;

  // Scoreboard/model state, written only by the monitor
  logic [33:0] exp0 [$];
  logic [33:0] exp1 [$];
  bit  acc0 = 1'b0, acc1 = 1'b0, outst = 1'b0, out_id = 1'b0, prio_m = 1'b0, was_rst = 1'b1;
  bit  prev_v0 = 1'b0, prev_v1 = 1'b0;
  logic [33:0] prev_d0 = '0, prev_d1 = '0;
  int  acc_cyc = 0, g0_m = 0, g1_m = 0, conf_m = 0, stat_done = 0;
  int  total = 0, bad = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Driver: presents queued ops, drops valid after a seen acceptance
  bit seen0 = 1'b0, seen1 = 1'b0;
  always @(posedge clk) begin
    #1;
    if (acc0 != seen0) begin seen0 = acc0; req0_valid_i = 1'b0; end
    if (acc1 != seen1) begin seen1 = acc1; req1_valid_i = 1'b0; end
    if (!req0_valid_i && rd0 != wr0 && (!gaps || $urandom_range(0, 3) != 0)) begin
      req0_ctr_i = st0[rd0].ctr; req0_a_i = st0[rd0].a; req0_b_i = st0[rd0].b;
      req0_valid_i = 1'b1; rd0++;
    end
    if (!req1_valid_i && rd1 != wr1 && (!gaps || $urandom_range(0, 3) != 0)) begin
      req1_ctr_i = st1[rd1].ctr; req1_a_i = st1[rd1].a; req1_b_i = st1[rd1].b;
      req1_valid_i = 1'b1; rd1++;
    end
    rsp0_ready_i = rr_rand ? ($urandom_range(0, 2) != 0) : man_rdy0;
    rsp1_ready_i = rr_rand ? ($urandom_range(0, 2) != 0) : man_rdy1;
  end

  // Monitor: transaction-level model of grants, latency and routing
  always @(negedge clk) begin : mon
    logic e0, e1, ev0, ev1;
    logic [33:0] r0, r1;
    if (rst) begin
      outst = 1'b0; prio_m = 1'b0; was_rst = 1'b1;
      exp0.delete(); exp1.delete();
      prev_v0 = 1'b0; prev_v1 = 1'b0;
      g0_m = 0; g1_m = 0; conf_m = 0;
    end else begin
      r0 = {rsp0_less_o, rsp0_zero_o, rsp0_p_o};
      r1 = {rsp1_less_o, rsp1_zero_o, rsp1_p_o};
      if (was_rst) begin
        chk("rst_alu_operands", {alu_ctr_o, alu_a_o, alu_b_o}, 72'd0);
        chk("rst_rsp0_data", r0, 72'd0);
        chk("rst_rsp1_data", r1, 72'd0);
        was_rst = 1'b0;
      end
`ifdef RISCV_ALU_ARB_STAT_EN
      if (stat_req != stat_done) begin
        chk("stat_grant0", stat_grant0_o, g0_m);
        chk("stat_grant1", stat_grant1_o, g1_m);
        chk("stat_conflict", stat_conflict_o, conf_m);
        stat_done = stat_req;
      end
`endif
      e0 = !outst && req0_valid_i && (!req1_valid_i || !prio_m);
      e1 = !outst && req1_valid_i && !e0;
      if (!outst && req0_valid_i && req1_valid_i) conf_m++;
      chk("req0_ready", req0_ready_o, e0);
      chk("req1_ready", req1_ready_o, e1);

      ev0 = outst && !out_id && (cyc >= acc_cyc + 2);
      ev1 = outst &&  out_id && (cyc >= acc_cyc + 2);
      chk("rsp0_valid", rsp0_valid_o, ev0);
      chk("rsp1_valid", rsp1_valid_o, ev1);
      if (prev_v0 && rsp0_valid_o) chk("rsp0_hold", r0, prev_d0);
      if (prev_v1 && rsp1_valid_o) chk("rsp1_hold", r1, prev_d1);
      prev_v0 = rsp0_valid_o && !rsp0_ready_i; prev_d0 = r0;
      prev_v1 = rsp1_valid_o && !rsp1_ready_i; prev_d1 = r1;

      if (ev0 && rsp0_valid_o && rsp0_ready_i) begin
        if (exp0.size() != 0) chk("rsp0_data", r0, exp0.pop_front());
        outst = 1'b0; prio_m = 1'b1;
      end else if (ev1 && rsp1_valid_o && rsp1_ready_i) begin
        if (exp1.size() != 0) chk("rsp1_data", r1, exp1.pop_front());
        outst = 1'b0; prio_m = 1'b0;
      end

      if (e0 && req0_ready_o) begin
        exp0.push_back(alu_ref(req0_ctr_i, req0_a_i, req0_b_i));
        outst = 1'b1; out_id = 1'b0; acc_cyc = cyc; g0_m++; acc0 = ~acc0;
      end else if (e1 && req1_ready_o) begin
        exp1.push_back(alu_ref(req1_ctr_i, req1_a_i, req1_b_i));
        outst = 1'b1; out_id = 1'b1; acc_cyc = cyc; g1_m++; acc1 = ~acc1;
      end
    end
  end

  logic [3:0] ctrs [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                            4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};

  task automatic push0(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    st0[wr0] = '{ctr: c, a: a, b: b}; wr0++;
  endtask

  task automatic push1(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    st1[wr1] = '{ctr: c, a: a, b: b}; wr1++;
  endtask

  task automatic push_rand(input bit which);
    logic [31:0] a, b;
    logic [3:0]  c;
    c = ctrs[$urandom_range(0, 9)];
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    if (which) push1(c, a, b);
    else       push0(c, a, b);
  endtask

  task automatic rst_pulse();
    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
  endtask

  task automatic bail(input string what);
    $display("FAIL %s: bound expired at cycle %0d", what, cyc);
    $fatal(1, "bench stopped");
  endtask

  task automatic wait_acc();
    int n = 0;
    while (!outst) begin
      @(negedge clk); #1; n++;
      if (n > 200) bail("wait_accept");
    end
  endtask

  task automatic wait_resp();
    int n = 0;
    while (!(outst && cyc >= acc_cyc + 2)) begin
      @(negedge clk); #1; n++;
      if (n > 200) bail("wait_response");
    end
  endtask

  task automatic drain();
    int n = 0;
    while (rd0 != wr0 || rd1 != wr1 || req0_valid_i || req1_valid_i || outst) begin
      @(negedge clk); #1; n++;
      if (n > 5000) bail("drain");
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Single requester: add on channel 0
    push0(4'b0000, 32'd5, 32'd3);
    drain();

    // Requester 1 alone: sub to zero, then signed compare
    push1(4'b1000, 32'd7, 32'd7);
    push1(4'b0010, 32'hFFFF_FFFF, 32'd1);
    drain();

    // Both requesters contending from reset
    rst_pulse();
    for (int i = 0; i < 4; i++) begin
      push_rand(1'b0);
      push_rand(1'b1);
    end
    drain();
    stat_req++;
    repeat (2) @(negedge clk);

    // Response backpressure with requester 1 waiting
    man_rdy0 = 1'b0;
    push0(4'b0000, 32'd100, 32'd200);
    wait_resp();
    push1(4'b0111, 32'hF0F0_1234, 32'h0FF0_FFFF);
    repeat (6) @(posedge clk);
    man_rdy0 = 1'b1;
    drain();

    // Reset during EXEC, then during RESP, then a clean operation
    push0(4'b0000, 32'd10, 32'd20);
    wait_acc();
    rst_pulse();
    drain();
    man_rdy0 = 1'b0;
    push0(4'b0100, 32'h1234_5678, 32'h8765_4321);
    wait_resp();
    rst_pulse();
    man_rdy0 = 1'b1;
    push0(4'b0000, 32'd1, 32'd2);
    drain();

    // Shift boundaries
    push0(4'b0001, 32'd1, 32'd31);
    push1(4'b1101, 32'h8000_0000, 32'd4);
    drain();

    // Randomized traffic with gaps and random response backpressure
    gaps = 1'b1;
    rr_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      push_rand(1'b0);
      push_rand(1'b1);
    end
    drain();
    rr_rand = 1'b0;
    gaps = 1'b0;
    stat_req++;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
